// File: rtl/extender_pkg.sv
// Shared widths and extension-mode encoding for the immediate extender.
package extender_pkg;

  localparam int unsigned IMM_W_DEF = 16;
  localparam int unsigned OUT_W_DEF = 32;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_SIGN = 2'b01,
    MODE_LUI  = 2'b10
  } mode_e;

  // lui takes priority; the ternaries keep an X on either select visible in the mode
  function automatic mode_e decode_mode(input logic lui, input logic sign_ext);
    return lui ? MODE_LUI : (sign_ext ? MODE_SIGN : MODE_ZERO);
  endfunction

endpackage

// File: rtl/extender_core.sv
// Purely combinational immediate extension: zero, sign or upper-half placement.
module extender_core
  import extender_pkg::*;
#(
  parameter int unsigned IMM_W = IMM_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [IMM_W-1:0] i_imm,
  input  mode_e            i_mode,
  output logic [OUT_W-1:0] o_ext
);

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_lui;
  logic             w_is_lui;
  logic             w_is_sign;

  assign w_zext = {{(OUT_W-IMM_W){1'b0}}, i_imm};
  assign w_sext = {{(OUT_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign w_lui  = {i_imm, {(OUT_W-IMM_W){1'b0}}};

  // Equality compares yield X for an X mode, so the ternaries below propagate it
  assign w_is_lui  = (i_mode == MODE_LUI);
  assign w_is_sign = (i_mode == MODE_SIGN);

  assign o_ext = w_is_lui ? w_lui : (w_is_sign ? w_sext : w_zext);

endmodule

// File: rtl/extender.sv
// Immediate extender top: mode decode, combinational core and an optional
// registered output stage enabled by the EXTENDER_REG_OUT_EN macro.
module extender
  import extender_pkg::*;
#(
  parameter int unsigned IMM_W = IMM_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [IMM_W-1:0] imm,
  input  logic             signExtImm,
  input  logic             luiImm,
  input  logic             inValid,
`ifdef EXTENDER_REG_OUT_EN
  output logic [OUT_W-1:0] extImmQ,
  output logic             outValid,
`endif
  output logic [OUT_W-1:0] extImm
);

  mode_e            w_mode;
  logic [OUT_W-1:0] w_ext;

  assign w_mode = decode_mode(luiImm, signExtImm);

  extender_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_imm  (imm),
    .i_mode (w_mode),
    .o_ext  (w_ext)
  );

  assign extImm = w_ext;

`ifdef EXTENDER_REG_OUT_EN
  logic [OUT_W-1:0] r_extImmQ;
  logic             r_outValid;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_extImmQ  <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= inValid;
      if (inValid) begin
        r_extImmQ <= w_ext;
      end
    end
  end

  assign extImmQ  = r_extImmQ;
  assign outValid = r_outValid;
`else
  logic w_unused;
  assign w_unused = &{1'b0, Clock, Reset_n, inValid};
`endif

endmodule

// File: tb/tb_extender.sv
// Self-checking bench for extender: directed vector table, randomized model
// comparison, and the registered-path sequences when EXTENDER_REG_OUT_EN is set.
module tb_extender;

  localparam int IMM_W = 16;
  localparam int OUT_W = 32;

  logic             Clock = 1'b0;
  logic             Reset_n = 1'b1;
  logic [IMM_W-1:0] imm = '0;
  logic             signExtImm = 1'b0;
  logic             luiImm = 1'b0;
  logic             inValid = 1'b0;
  logic [OUT_W-1:0] extImm;
`ifdef EXTENDER_REG_OUT_EN
  logic [OUT_W-1:0] extImmQ;
  logic             outValid;
`endif

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  extender #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .imm        (imm),
    .signExtImm (signExtImm),
    .luiImm     (luiImm),
    .inValid    (inValid),
`ifdef EXTENDER_REG_OUT_EN
    .extImmQ    (extImmQ),
    .outValid   (outValid),
`endif
    .extImm     (extImm)
  );

  // Reference: extension expressed as integer arithmetic on the immediate value
  function automatic logic [OUT_W-1:0] model(input logic [IMM_W-1:0] v,
                                             input logic s, input logic l);
    longint r;
    r = longint'(v);
    if (l)
      r = r * (longint'(1) << (OUT_W - IMM_W));
    else if (s && r >= (longint'(1) << (IMM_W - 1)))
      r = r + (longint'(1) << OUT_W) - (longint'(1) << IMM_W);
    return r[OUT_W-1:0];
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [IMM_W-1:0] imm;
    logic             s;
    logic             l;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

`ifdef EXTENDER_REG_OUT_EN
  logic [OUT_W-1:0] expQ;
  logic             expV;

  task automatic tick_and_check(input string name);
    @(posedge Clock);
    if (inValid) expQ = model(imm, signExtImm, luiImm);
    expV = inValid;
    #1;
    check({name, "_q"}, extImmQ, expQ);
    check({name, "_v"}, {{(OUT_W-1){1'b0}}, outValid}, {{(OUT_W-1){1'b0}}, expV});
  endtask
`endif

  initial begin
    vecs[0]  = '{16'h0EB7, 1'b1, 1'b0, 32'h00000EB7};
    vecs[1]  = '{16'h8EB7, 1'b1, 1'b0, 32'hFFFF8EB7};
    vecs[2]  = '{16'h8EB7, 1'b0, 1'b0, 32'h00008EB7};
    vecs[3]  = '{16'h8EB7, 1'b1, 1'b1, 32'h8EB70000};
    vecs[4]  = '{16'h8EB7, 1'b0, 1'b1, 32'h8EB70000};
    vecs[5]  = '{16'h0000, 1'b1, 1'b0, 32'h00000000};
    vecs[6]  = '{16'hFFFF, 1'b1, 1'b0, 32'hFFFFFFFF};
    vecs[7]  = '{16'hFFFF, 1'b0, 1'b0, 32'h0000FFFF};
    vecs[8]  = '{16'h7FFF, 1'b1, 1'b0, 32'h00007FFF};
    vecs[9]  = '{16'h8000, 1'b1, 1'b0, 32'hFFFF8000};
    vecs[10] = '{16'hFFFF, 1'b0, 1'b1, 32'hFFFF0000};
    vecs[11] = '{16'h0001, 1'b1, 1'b1, 32'h00010000};

    // Combinational path from the vector table
    for (int i = 0; i < 12; i++) begin
      imm = vecs[i].imm; signExtImm = vecs[i].s; luiImm = vecs[i].l;
      #1;
      check($sformatf("vec%0d", i), extImm, vecs[i].exp);
    end

    // Randomized combinational comparison
    for (int i = 0; i < 200; i++) begin
      imm = IMM_W'($urandom); signExtImm = 1'($urandom); luiImm = 1'($urandom);
      #1;
      check("rand_comb", extImm, model(imm, signExtImm, luiImm));
    end

    // extImm must not depend on reset
    Reset_n = 1'b0;
    imm = 16'h8123; signExtImm = 1'b1; luiImm = 1'b0;
    #1;
    check("comb_in_reset", extImm, 32'hFFFF8123);
    Reset_n = 1'b1;
    #1;

`ifdef EXTENDER_REG_OUT_EN
    // Asynchronous reset state without a clock edge
    @(posedge Clock); #2;
    Reset_n = 1'b0;
    #1;
    check("reset_q", extImmQ, '0);
    check("reset_v", {31'b0, outValid}, '0);
    expQ = '0; expV = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;

    // Directed capture then hold
    imm = 16'h8EB7; signExtImm = 1'b1; luiImm = 1'b0; inValid = 1'b1;
    tick_and_check("cap");
    check("cap_exact", extImmQ, 32'hFFFF8EB7);
    imm = 16'h1234; inValid = 1'b0;
    tick_and_check("hold");
    check("hold_exact", extImmQ, 32'hFFFF8EB7);

    // Randomized registered path
    for (int i = 0; i < 150; i++) begin
      imm = IMM_W'($urandom); signExtImm = 1'($urandom);
      luiImm = 1'($urandom); inValid = 1'($urandom);
      tick_and_check("rand_reg");
    end

    // Reset pulse mid-operation, then first capture after release
    inValid = 1'b1; imm = 16'h4321; luiImm = 1'b1;
    tick_and_check("pre_rst");
    #2;
    Reset_n = 1'b0;
    imm = 16'h00AA; luiImm = 1'b0; signExtImm = 1'b0;
    #1;
    check("midrst_q", extImmQ, '0);
    check("midrst_v", {31'b0, outValid}, '0);
    check("midrst_comb", extImm, 32'h000000AA);
    expQ = '0; expV = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    tick_and_check("post_rst");
    check("post_rst_exact", extImmQ, 32'h000000AA);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/extender.md
EXTENDER -- requirements
Module: extender

Interface
- REQ-001: Parameter IMM_W, default 16, width of the immediate input.
- REQ-002: Parameter OUT_W, default 32, width of the extended result; SHALL be greater than IMM_W.
- REQ-003: Clock  input  1  single clock, rising-edge active.
- REQ-004: Reset_n  input  1  reset, asynchronous and active-low.
- REQ-005: imm  input  IMM_W  immediate field to extend.
- REQ-006: signExtImm  input  1  1 = sign-extend, 0 = zero-extend.
- REQ-007: luiImm  input  1  1 = place imm in the upper half, lower bits zero; overrides signExtImm.
- REQ-008: inValid  input  1  qualifies imm/signExtImm/luiImm for the registered path.
- REQ-009: extImm  output  OUT_W  combinational extended result.
- REQ-010: extImmQ  output  OUT_W  registered extended result (present only with the macro in REQ-022).
- REQ-011: outValid  output  1  qualifies extImmQ (present only with the macro in REQ-022).

Function
- REQ-012: With luiImm=0 and signExtImm=1, extImm SHALL be {(OUT_W-IMM_W) copies of imm[IMM_W-1], imm}.
- REQ-013: With luiImm=0 and signExtImm=0, extImm SHALL be {(OUT_W-IMM_W) zeros, imm}.
- REQ-014: With luiImm=1, extImm SHALL be imm shifted left so that imm occupies bits [OUT_W-1:OUT_W-IMM_W] and all lower bits are 0, regardless of signExtImm.
- REQ-015: extImm SHALL be purely combinational: no clock dependence, valid within the same delta as the input change, and independent of Reset_n.
- REQ-016: extImm[IMM_W-1:0] SHALL equal imm in both non-lui modes; only the upper bits differ by mode.
- REQ-017: The registered path SHALL capture extImm into extImmQ on each rising Clock edge where inValid=1, with 1-cycle latency.
- REQ-018: extImmQ SHALL hold its value when inValid=0.
- REQ-019: outValid SHALL be inValid delayed by one Clock cycle.
- REQ-020: X or Z on signExtImm or luiImm SHALL propagate to extImm; no X masking.

Reset
- REQ-021: While Reset_n=0, extImmQ SHALL be 0 and outValid SHALL be 0, asynchronously; extImm is unaffected; the first capture occurs on the first rising edge after Reset_n deasserts.

Configuration
- REQ-022: Macro EXTENDER_REG_OUT_EN: defined -> extImmQ, outValid and the registered path of REQ-017..REQ-019/REQ-021 exist; undefined -> those ports and flops are absent, Clock/Reset_n remain as unused inputs, and extImm behaviour is unchanged.

Structure
- REQ-023: A shared package extender_pkg SHALL hold the IMM_W/OUT_W defaults and the mode encoding constants (MODE_ZERO, MODE_SIGN, MODE_LUI).
- REQ-024: Combinational extension SHALL live in sub-module extender_core; extender adds mode decode and the optional register stage.

Verification
- REQ-025: imm=0000_1110_1011_0111, signExtImm=1, luiImm=0 -> extImm=0x00000EB7.
- REQ-026: imm=1000_1110_1011_0111, signExtImm=1, luiImm=0 -> extImm=0xFFFF8EB7.
- REQ-027: imm=1000_1110_1011_0111, signExtImm=0, luiImm=0 -> extImm=0x00008EB7.
- REQ-028: imm=0x8EB7, luiImm=1, signExtImm=1 -> extImm=0x8EB70000.
- REQ-029: EXTENDER_REG_OUT_EN defined, inValid=1 with imm=0x8EB7, signExtImm=1 -> one edge later extImmQ=0xFFFF8EB7, outValid=1; then inValid=0 -> extImmQ holds, outValid=0.
- REQ-030: Reset_n pulsed low mid-operation -> extImmQ=0 and outValid=0 immediately, without a clock edge; extImm keeps tracking imm.
